// File: rtl/nm_frame_counter.sv
`default_nettype none
// ==== nm_frame_counter : programmable N/M sub-frame/frame counter with divided clocks (rev 1.0) ====
// Ratio changes go through a shadow register and take effect only in IDLE or on the (N,M)->(1,1) wrap.
module nm_frame_counter #(
  parameter logic [3:0] N_RST = 4'd8,
  parameter logic [1:0] M_RST = 2'd3
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cfg_load,
  input  logic [3:0] N_in,
  input  logic [1:0] M_in,
  output logic [3:0] N,
  output logic [1:0] M,
  output logic [3:0] N_counter,
  output logic [1:0] M_counter,
  output logic       DIV_N,
  output logic       DIV_M,
  output logic       frame_done,
  output logic       cfg_pending,
  output logic       cfg_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] n_q, n_d, sh_n_q, sh_n_d, n_cnt_q, n_cnt_d;
  logic [1:0] m_q, m_d, sh_m_q, sh_m_d, m_cnt_q, m_cnt_d;
  logic       div_n_q, div_n_d, div_m_q, div_m_d;
  logic       frame_done_q, frame_done_d;
  logic       pend_q, pend_d, err_q, err_d;
  logic       apply, cfg_bad;
  logic [4:0] n_half;
  logic [2:0] m_half;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    m_d          = m_q;
    sh_n_d       = sh_n_q;
    sh_m_d       = sh_m_q;
    n_cnt_d      = n_cnt_q;
    m_cnt_d      = m_cnt_q;
    div_n_d      = div_n_q;
    div_m_d      = div_m_q;
    frame_done_d = frame_done_q;
    pend_d       = pend_q;
    apply        = 1'b0;
    n_half       = 5'd0;
    m_half       = 3'd0;

    cfg_bad = (N_in == 4'd0) || (M_in == 2'd0);
    err_d   = cfg_load && cfg_bad;

    case (state_q)
      IDLE: begin
        apply = pend_q;
        if (en) begin
          state_d = RUN;
          n_cnt_d = 4'd1;
          m_cnt_d = 2'd1;
        end
      end
      RUN: begin
        if (en) begin
          if (n_cnt_q >= n_q) begin
            n_cnt_d = 4'd1;
            if (m_cnt_q >= m_q) begin
              m_cnt_d = 2'd1;
              apply   = pend_q;
            end else begin
              m_cnt_d = m_cnt_q + 2'd1;
            end
          end else begin
            n_cnt_d = n_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The wrap applies the shadow as it stood before this edge; a load on the same edge waits a frame.
    if (apply) begin
      n_d    = sh_n_q;
      m_d    = sh_m_q;
      pend_d = 1'b0;
    end
    if (cfg_load && !cfg_bad) begin
      sh_n_d = N_in;
      sh_m_d = M_in;
      pend_d = 1'b1;
    end

    // Divided outputs follow the next-state counters and ratio so they move with the counters.
    if (en) begin
      n_half       = ({1'b0, n_d} + 5'd1) >> 1;
      m_half       = ({1'b0, m_d} + 3'd1) >> 1;
      div_n_d      = (n_cnt_d != 4'd0) && ({1'b0, n_cnt_d} <= n_half);
      div_m_d      = (m_cnt_d != 2'd0) && ({1'b0, m_cnt_d} <= m_half);
      frame_done_d = (n_cnt_d == n_d) && (m_cnt_d == m_d);
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= N_RST;
      m_q          <= M_RST;
      sh_n_q       <= N_RST;
      sh_m_q       <= M_RST;
      n_cnt_q      <= 4'd0;
      m_cnt_q      <= 2'd0;
      div_n_q      <= 1'b0;
      div_m_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      m_q          <= m_d;
      sh_n_q       <= sh_n_d;
      sh_m_q       <= sh_m_d;
      n_cnt_q      <= n_cnt_d;
      m_cnt_q      <= m_cnt_d;
      div_n_q      <= div_n_d;
      div_m_q      <= div_m_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
    end
  end

  assign N           = n_q;
  assign M           = m_q;
  assign N_counter   = n_cnt_q;
  assign M_counter   = m_cnt_q;
  assign DIV_N       = div_n_q;
  assign DIV_M       = div_m_q;
  assign frame_done  = frame_done_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nm_frame_counter.sv
`default_nettype none
// ==== tb_nm_frame_counter : directed and randomized checks against a frame-position model (rev 1.0) ====
module tb_nm_frame_counter;

  logic       clk_out = 1'b0;
  logic       rst_n = 1'b0, en = 1'b0, cfg_load = 1'b0;
  logic [3:0] N_in = 4'd0;
  logic [1:0] M_in = 2'd0;
  logic [3:0] N, N_counter;
  logic [1:0] M, M_counter;
  logic       DIV_N, DIV_M, frame_done, cfg_pending, cfg_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: ratio, shadow and a flat position 0..N*M-1 inside the frame.
  bit md_started, md_pend, md_err;
  int md_pos, md_n, md_m, md_sn, md_sm;

  nm_frame_counter #(.N_RST(4'd8), .M_RST(2'd3)) dut (
    .clk_out(clk_out), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
    .N_in(N_in), .M_in(M_in), .N(N), .M(M), .N_counter(N_counter),
    .M_counter(M_counter), .DIV_N(DIV_N), .DIV_M(DIV_M),
    .frame_done(frame_done), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  always #5 clk_out = ~clk_out;

  wire [16:0] dut_vec = {N, M, N_counter, M_counter, DIV_N, DIV_M, frame_done, cfg_pending, cfg_err};

  function automatic logic [16:0] exp_vec();
    int  nc, mc;
    logic dn, dm, fd;
    nc = 0; mc = 0; dn = 1'b0; dm = 1'b0; fd = 1'b0;
    if (md_started) begin
      nc = md_pos % md_n + 1;
      mc = md_pos / md_n + 1;
      dn = (nc <= (md_n + 1) / 2);
      dm = (mc <= (md_m + 1) / 2);
      fd = (md_pos == md_n * md_m - 1);
    end
    return {4'(md_n), 2'(md_m), 4'(nc), 2'(mc), dn, dm, fd, md_pend, md_err};
  endfunction

  task automatic model_step();
    bit apply;
    apply = 1'b0;
    if (!rst_n) begin
      md_started = 1'b0; md_pos = 0; md_n = 8; md_m = 3;
      md_sn = 8; md_sm = 3; md_pend = 1'b0; md_err = 1'b0;
      return;
    end
    if (!md_started) begin
      apply = md_pend;
      if (en) begin md_started = 1'b1; md_pos = 0; end
    end else if (en) begin
      if (md_pos == md_n * md_m - 1) begin md_pos = 0; apply = md_pend; end
      else md_pos = md_pos + 1;
    end
    if (apply) begin md_n = md_sn; md_m = md_sm; md_pend = 1'b0; end
    md_err = cfg_load && (N_in == 0 || M_in == 0);
    if (cfg_load && N_in != 0 && M_in != 0) begin
      md_sn = int'(N_in); md_sm = int'(M_in); md_pend = 1'b1;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit ld, input int ni, input int mi);
    rst_n = r; en = e; cfg_load = ld; N_in = 4'(ni); M_in = 2'(mi);
    @(posedge clk_out);
    model_step();
    #1;
  endtask

  task automatic setup(input int n, input int m);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, n, m);
    cycle(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0, 0);
    tests_run++;
    if (dut_vec !== {4'd8, 2'd3, 4'd0, 2'd0, 5'b0}) begin
      tests_failed++; $display("FAIL reset_state got=%h want=%h", dut_vec, {4'd8, 2'd3, 4'd0, 2'd0, 5'b0});
    end
    cycle(0, 1, 1, 5, 1);
    tests_run++;
    if (dut_vec !== {4'd8, 2'd3, 4'd0, 2'd0, 5'b0}) begin
      tests_failed++; $display("FAIL reset_overrides got=%h want=%h", dut_vec, {4'd8, 2'd3, 4'd0, 2'd0, 5'b0});
    end
  endtask

  task automatic test_default_sequence();
    int en_s[7] = '{1, 2, 3, 1, 2, 3, 1};
    int em_s[7] = '{1, 1, 1, 2, 2, 2, 1};
    bit edn[7]  = '{1, 1, 0, 1, 1, 0, 1};
    bit edm[7]  = '{1, 1, 1, 0, 0, 0, 1};
    bit efd[7]  = '{0, 0, 0, 0, 0, 1, 0};
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 1, 3, 2);
    tests_run++;
    if (cfg_pending !== 1'b1 || N !== 4'd8) begin
      tests_failed++; $display("FAIL idle_load pend=%b N=%0d want pend=1 N=8", cfg_pending, N);
    end
    cycle(1, 0, 0, 0, 0);
    tests_run++;
    if (cfg_pending !== 1'b0 || N !== 4'd3 || M !== 2'd2 || N_counter !== 4'd0) begin
      tests_failed++; $display("FAIL idle_apply pend=%b N=%0d M=%0d nc=%0d want 0/3/2/0", cfg_pending, N, M, N_counter);
    end
    for (int i = 0; i < 7; i++) begin
      cycle(1, 1, 0, 0, 0);
      tests_run++;
      if (N_counter !== 4'(en_s[i]) || M_counter !== 2'(em_s[i]) || DIV_N !== edn[i] ||
          DIV_M !== edm[i] || frame_done !== efd[i]) begin
        tests_failed++;
        $display("FAIL default_seq[%0d] got n=%0d m=%0d dn=%b dm=%b fd=%b want n=%0d m=%0d dn=%b dm=%b fd=%b",
                 i, N_counter, M_counter, DIV_N, DIV_M, frame_done, en_s[i], em_s[i], edn[i], edm[i], efd[i]);
      end
    end
  endtask

  task automatic test_reconfig();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 5, 1);
    tests_run++;
    if (cfg_pending !== 1'b1 || N !== 4'd3 || M !== 2'd2 || N_counter !== 4'd3) begin
      tests_failed++; $display("FAIL reconfig_pend pend=%b N=%0d M=%0d nc=%0d want 1/3/2/3", cfg_pending, N, M, N_counter);
    end
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0);
    tests_run++;
    if (N !== 4'd3 || M !== 2'd2 || N_counter !== 4'd3 || M_counter !== 2'd2 || frame_done !== 1'b1) begin
      tests_failed++; $display("FAIL reconfig_hold N=%0d M=%0d nc=%0d mc=%0d fd=%b want 3/2/3/2/1", N, M, N_counter, M_counter, frame_done);
    end
    cycle(1, 1, 0, 0, 0);
    tests_run++;
    if (dut_vec !== {4'd5, 2'd1, 4'd1, 2'd1, 5'b11000}) begin
      tests_failed++; $display("FAIL reconfig_apply got=%h want=%h", dut_vec, {4'd5, 2'd1, 4'd1, 2'd1, 5'b11000});
    end
  endtask

  task automatic test_illegal();
    cycle(1, 1, 1, 0, 2);
    tests_run++;
    if (cfg_err !== 1'b1 || cfg_pending !== 1'b0 || N !== 4'd5 || M !== 2'd1) begin
      tests_failed++; $display("FAIL illegal_cfg err=%b pend=%b N=%0d M=%0d want 1/0/5/1", cfg_err, cfg_pending, N, M);
    end
    cycle(1, 1, 0, 0, 0);
    tests_run++;
    if (cfg_err !== 1'b0 || cfg_pending !== 1'b0) begin
      tests_failed++; $display("FAIL illegal_pulse err=%b pend=%b want 0/0", cfg_err, cfg_pending);
    end
  endtask

  task automatic test_freeze();
    setup(3, 2);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0);
      tests_run++;
      if (dut_vec !== {4'd3, 2'd2, 4'd2, 2'd1, 5'b11000}) begin
        tests_failed++; $display("FAIL freeze[%0d] got=%h want=%h", i, dut_vec, {4'd3, 2'd2, 4'd2, 2'd1, 5'b11000});
      end
    end
    cycle(1, 1, 0, 0, 0);
    tests_run++;
    if (N_counter !== 4'd3 || M_counter !== 2'd1 || DIV_N !== 1'b0) begin
      tests_failed++; $display("FAIL freeze_resume nc=%0d mc=%0d dn=%b want 3/1/0", N_counter, M_counter, DIV_N);
    end
  endtask

  task automatic test_extreme_1_1();
    setup(1, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0, 0, 0);
      tests_run++;
      if (dut_vec !== {4'd1, 2'd1, 4'd1, 2'd1, 5'b11100}) begin
        tests_failed++; $display("FAIL ratio_1_1[%0d] got=%h want=%h", i, dut_vec, {4'd1, 2'd1, 4'd1, 2'd1, 5'b11100});
      end
    end
  endtask

  task automatic test_ratio_15_3();
    int dn_hi = 0, dm_hi = 0, fd_n = 0, starts = 0;
    setup(15, 3);
    for (int i = 0; i < 90; i++) begin
      cycle(1, 1, 0, 0, 0);
      dn_hi += int'(DIV_N);
      dm_hi += int'(DIV_M);
      fd_n  += int'(frame_done);
      if (N_counter == 4'd1 && M_counter == 2'd1) starts++;
    end
    tests_run++;
    if (dn_hi != 48 || dm_hi != 60 || fd_n != 2 || starts != 2) begin
      tests_failed++; $display("FAIL ratio_15_3 divn_hi=%0d divm_hi=%0d fd=%0d starts=%0d want 48/60/2/2", dn_hi, dm_hi, fd_n, starts);
    end
  endtask

  task automatic test_reset_midframe();
    setup(3, 2);
    cycle(1, 1, 1, 7, 3);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);
    tests_run++;
    if (N_counter !== 4'd2 || M_counter !== 2'd2 || cfg_pending !== 1'b1) begin
      tests_failed++; $display("FAIL pre_reset nc=%0d mc=%0d pend=%b want 2/2/1", N_counter, M_counter, cfg_pending);
    end
    cycle(0, 1, 0, 0, 0);
    tests_run++;
    if (dut_vec !== {4'd8, 2'd3, 4'd0, 2'd0, 5'b0}) begin
      tests_failed++; $display("FAIL reset_midframe got=%h want=%h", dut_vec, {4'd8, 2'd3, 4'd0, 2'd0, 5'b0});
    end
    cycle(1, 0, 0, 0, 0);
    tests_run++;
    if (N !== 4'd8 || M !== 2'd3 || cfg_pending !== 1'b0) begin
      tests_failed++; $display("FAIL reset_discard N=%0d M=%0d pend=%b want 8/3/0", N, M, cfg_pending);
    end
  endtask

  task automatic test_random();
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      tests_run++;
      if (dut_vec !== exp_vec()) begin
        tests_failed++; $display("FAIL random[%0d] got=%h want=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_sequence();
    test_reconfig();
    test_illegal();
    test_freeze();
    test_extreme_1_1();
    test_ratio_15_3();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
